// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory copy/fill engine.
package dm_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      FIN  = 3'd4
   } state_t;

   localparam logic       MODE_COPY       = 1'b0;
   localparam logic       MODE_FILL       = 1'b1;
   localparam int         WORD_BYTES      = 4;
   localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dm_copy_engine.sv
// Memory-port initiator that copies or fills a run of words, one access per state.
// All outputs are registered and are loaded on the transition into the state that owns them.
module dm_copy_engine
   import dm_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] checksum,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data,
   output logic [2:0]        state_dbg
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

   state_t            state;
   logic              mode_q;
   logic [ADDR_W-1:0] cur_src;
   logic [ADDR_W-1:0] cur_dst;
   logic [LEN_W-1:0]  remaining;
   logic [DATA_W-1:0] fill_q;
   logic              misaligned;

   assign misaligned = ((dst_addr[1:0] & ADDR_ALIGN_MASK) != 2'b00) ||
                       ((mode == MODE_COPY) && ((src_addr[1:0] & ADDR_ALIGN_MASK) != 2'b00));

   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mode_q     <= MODE_COPY;
         cur_src    <= '0;
         cur_dst    <= '0;
         remaining  <= '0;
         fill_q     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         checksum   <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         addr       <= '0;
         write_data <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q    <= mode;
                  cur_src   <= src_addr;
                  cur_dst   <= dst_addr;
                  remaining <= len;
                  fill_q    <= fill_value;
                  err       <= 1'b0;
                  checksum  <= '0;
                  if (len == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else if (misaligned) begin
                     state <= FIN;
                     err   <= 1'b1;
                     done  <= 1'b1;
                  end else if (mode == MODE_COPY) begin
                     state    <= RD;
                     busy     <= 1'b1;
                     mem_read <= 1'b1;
                     addr     <= src_addr;
                  end else begin
                     state      <= WR;
                     busy       <= 1'b1;
                     mem_write  <= 1'b1;
                     addr       <= dst_addr;
                     write_data <= fill_value;
                  end
               end
            end
            RD: begin
               state    <= CAP;
               mem_read <= 1'b0;
               addr     <= '0;
            end
            CAP: begin
               // write_data doubles as the word buffer: read_data is valid only this cycle.
               state      <= WR;
               mem_write  <= 1'b1;
               addr       <= cur_dst;
               write_data <= read_data;
            end
            WR: begin
               checksum  <= checksum + write_data;
               cur_src   <= cur_src + STEP;
               cur_dst   <= cur_dst + STEP;
               remaining <= remaining - LEN_W'(1);
               if (remaining == LEN_W'(1)) begin
                  state      <= FIN;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  mem_write  <= 1'b0;
                  addr       <= '0;
                  write_data <= '0;
               end else if (mode_q == MODE_COPY) begin
                  state      <= RD;
                  mem_write  <= 1'b0;
                  write_data <= '0;
                  mem_read   <= 1'b1;
                  addr       <= cur_src + STEP;
               end else begin
                  addr       <= cur_dst + STEP;
                  write_data <= fill_q;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Directed bench for dm_copy_engine paired with a 256-word registered-read memory model.
module tb_dm_copy_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [7:0]  len = '0;
   logic [31:0] fill_value = '0;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] checksum;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data = '0;
   logic [2:0]  state_dbg;

   logic [31:0] mem [256];
   logic        tb_we = 1'b0;
   logic [7:0]  tb_idx = '0;
   logic [31:0] tb_wd = '0;

   int          tests_run = 0;
   int          tests_failed = 0;

   logic [63:0] rd_mask;
   logic [63:0] wr_mask;
   logic [63:0] busy_mask;
   logic [31:0] wr_addr_at [64];
   int          done_cyc;
   int          done_cnt;
   int          both_cnt;
   logic        err_at_done;
   logic [31:0] cks_at_done;

   always #5 clk = ~clk;

   dm_copy_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mode       (mode),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
      .fill_value (fill_value),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .checksum   (checksum),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr       (addr),
      .write_data (write_data),
      .read_data  (read_data),
      .state_dbg  (state_dbg)
   );

   // Memory model: registered read, read wins over write, plus a bench-side load port.
   always @(posedge clk) begin
      if (mem_read) read_data <= mem[addr[9:2]];
      else if (mem_write) mem[addr[9:2]] <= write_data;
      if (tb_we) mem[tb_idx] <= tb_wd;
   end

   task automatic mem_load(input int idx, input logic [31:0] v);
      tb_we  = 1'b1;
      tb_idx = idx[7:0];
      tb_wd  = v;
      @(posedge clk); #1;
      tb_we  = 1'b0;
   endtask

   // Issue one command and log per-cycle activity; cycle 1 is the cycle after the start edge.
   task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d,
                        input logic [7:0] l, input logic [31:0] f, input int stray);
      rd_mask = '0; wr_mask = '0; busy_mask = '0;
      done_cyc = -1; done_cnt = 0; both_cnt = 0;
      err_at_done = 1'b0; cks_at_done = '0;
      for (int i = 0; i < 64; i++) wr_addr_at[i] = '0;
      mode = m; src_addr = s; dst_addr = d; len = l; fill_value = f; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 60; c++) begin
         start = (c == stray);
         if (c == stray) begin
            mode = 1'b1; dst_addr = 32'h100; len = 8'd5; fill_value = 32'h5555;
         end
         if (mem_read) rd_mask[c] = 1'b1;
         if (mem_write) begin
            wr_mask[c] = 1'b1;
            wr_addr_at[c] = addr;
         end
         if (busy) busy_mask[c] = 1'b1;
         if (mem_read && mem_write) both_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c; err_at_done = err; cks_at_done = checksum;
            end
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (done_cyc < 0) begin
         tests_run++; tests_failed++;
         $display("FAIL timeout: no done within 60 cycles (got none, required one)");
      end
   endtask

   task automatic test_reset();
      tests_run++;
      if ({busy, done, err, mem_read, mem_write} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b required 00000", {busy, done, err, mem_read, mem_write});
      end
      tests_run++;
      if (addr !== 32'h0 || write_data !== 32'h0 || checksum !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_data: addr=%h wdata=%h cks=%h required all 0", addr, write_data, checksum);
      end
   endtask

   task automatic test_copy();
      mem_load(0, 32'h11); mem_load(1, 32'h22); mem_load(2, 32'h33);
      issue(1'b0, 32'h00, 32'h40, 8'd3, 32'h0, -1);
      tests_run++;
      if (rd_mask !== 64'h92) begin
         tests_failed++; $display("FAIL copy_rd_cycles: got %h required 92", rd_mask);
      end
      tests_run++;
      if (wr_mask !== 64'h248) begin
         tests_failed++; $display("FAIL copy_wr_cycles: got %h required 248", wr_mask);
      end
      tests_run++;
      if (wr_addr_at[3] !== 32'h40 || wr_addr_at[6] !== 32'h44 || wr_addr_at[9] !== 32'h48) begin
         tests_failed++;
         $display("FAIL copy_wr_addr: got %h %h %h required 40 44 48", wr_addr_at[3], wr_addr_at[6], wr_addr_at[9]);
      end
      tests_run++;
      if (mem[16] !== 32'h11 || mem[17] !== 32'h22 || mem[18] !== 32'h33) begin
         tests_failed++;
         $display("FAIL copy_mem: got %h %h %h required 11 22 33", mem[16], mem[17], mem[18]);
      end
      tests_run++;
      if (cks_at_done !== 32'h66 || err_at_done !== 1'b0) begin
         tests_failed++; $display("FAIL copy_cks: got cks=%h err=%b required 66 0", cks_at_done, err_at_done);
      end
      tests_run++;
      if (done_cyc != 10 || done_cnt != 1 || both_cnt != 0) begin
         tests_failed++;
         $display("FAIL copy_done: got cyc=%0d cnt=%0d both=%0d required 10 1 0", done_cyc, done_cnt, both_cnt);
      end
   endtask

   task automatic test_fill();
      issue(1'b1, 32'h0, 32'h80, 8'd4, 32'hDEADBEEF, -1);
      tests_run++;
      if (wr_mask !== 64'h1E || rd_mask !== 64'h0) begin
         tests_failed++; $display("FAIL fill_cycles: got wr=%h rd=%h required 1e 0", wr_mask, rd_mask);
      end
      tests_run++;
      if (wr_addr_at[1] !== 32'h80 || wr_addr_at[2] !== 32'h84 ||
          wr_addr_at[3] !== 32'h88 || wr_addr_at[4] !== 32'h8C) begin
         tests_failed++;
         $display("FAIL fill_addr: got %h %h %h %h required 80 84 88 8c",
                  wr_addr_at[1], wr_addr_at[2], wr_addr_at[3], wr_addr_at[4]);
      end
      tests_run++;
      if (cks_at_done !== 32'h7AB6FBBC || done_cyc != 5) begin
         tests_failed++; $display("FAIL fill_done: got cks=%h cyc=%0d required 7ab6fbbc 5", cks_at_done, done_cyc);
      end
      tests_run++;
      if (mem[32] !== 32'hDEADBEEF || mem[35] !== 32'hDEADBEEF) begin
         tests_failed++; $display("FAIL fill_mem: got %h %h required deadbeef", mem[32], mem[35]);
      end
   endtask

   task automatic test_misaligned();
      issue(1'b0, 32'h02, 32'h40, 8'd2, 32'h0, -1);
      tests_run++;
      if (err_at_done !== 1'b1 || done_cyc != 1) begin
         tests_failed++; $display("FAIL misalign_err: got err=%b cyc=%0d required 1 1", err_at_done, done_cyc);
      end
      tests_run++;
      if (rd_mask !== 64'h0 || wr_mask !== 64'h0 || busy_mask !== 64'h0) begin
         tests_failed++;
         $display("FAIL misalign_quiet: got rd=%h wr=%h busy=%h required 0", rd_mask, wr_mask, busy_mask);
      end
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (err !== 1'b1 || done !== 1'b0) begin
         tests_failed++; $display("FAIL misalign_hold: got err=%b done=%b required 1 0", err, done);
      end
      issue(1'b1, 32'h0, 32'hC0, 8'd1, 32'h7, -1);
      tests_run++;
      if (err_at_done !== 1'b0 || cks_at_done !== 32'h7 || done_cyc != 2) begin
         tests_failed++;
         $display("FAIL misalign_clear: got err=%b cks=%h cyc=%0d required 0 7 2", err_at_done, cks_at_done, done_cyc);
      end
   endtask

   task automatic test_len_zero();
      for (int m = 0; m < 2; m++) begin
         issue(m[0], 32'h0, 32'h40, 8'd0, 32'h9, -1);
         tests_run++;
         if (done_cyc != 1 || err_at_done !== 1'b0 || busy_mask !== 64'h0 ||
             rd_mask !== 64'h0 || wr_mask !== 64'h0 || cks_at_done !== 32'h0) begin
            tests_failed++;
            $display("FAIL len0_mode%0d: got cyc=%0d err=%b busy=%h rd=%h wr=%h cks=%h required 1 0 0 0 0 0",
                     m, done_cyc, err_at_done, busy_mask, rd_mask, wr_mask, cks_at_done);
         end
      end
   endtask

   task automatic test_busy_start();
      issue(1'b0, 32'h00, 32'h50, 8'd3, 32'h0, 2);
      tests_run++;
      if (done_cyc != 10 || done_cnt != 1 || wr_mask !== 64'h248 || busy_mask !== 64'h3FE) begin
         tests_failed++;
         $display("FAIL busy_start: got cyc=%0d cnt=%0d wr=%h busy=%h required 10 1 248 3fe",
                  done_cyc, done_cnt, wr_mask, busy_mask);
      end
      tests_run++;
      if (mem[20] !== 32'h11 || mem[21] !== 32'h22 || mem[22] !== 32'h33) begin
         tests_failed++;
         $display("FAIL busy_start_mem: got %h %h %h required 11 22 33", mem[20], mem[21], mem[22]);
      end
      issue(1'b0, 32'h00, 32'h70, 8'd1, 32'h0, 4);
      tests_run++;
      if (done_cyc != 4 || done_cnt != 1 || busy_mask !== 64'hE || mem[64] !== 32'h0 || mem[28] !== 32'h11) begin
         tests_failed++;
         $display("FAIL fin_start: got cyc=%0d cnt=%0d busy=%h m64=%h m28=%h required 4 1 e 0 11",
                  done_cyc, done_cnt, busy_mask, mem[64], mem[28]);
      end
   endtask

   task automatic test_overlap();
      mem_load(0, 32'hA); mem_load(1, 32'hB); mem_load(2, 32'hC); mem_load(3, 32'hD);
      issue(1'b0, 32'h00, 32'h04, 8'd3, 32'h0, -1);
      tests_run++;
      if (mem[1] !== 32'hA || mem[2] !== 32'hA || mem[3] !== 32'hA || cks_at_done !== 32'h1E) begin
         tests_failed++;
         $display("FAIL overlap: got %h %h %h cks=%h required a a a 1e", mem[1], mem[2], mem[3], cks_at_done);
      end
   endtask

   task automatic test_reset_mid();
      int seen_done;
      mem_load(0, 32'h101); mem_load(1, 32'h202); mem_load(2, 32'h303);
      mem_load(24, 32'hFFFF0000); mem_load(25, 32'hFFFF0000); mem_load(26, 32'hFFFF0000);
      mode = 1'b0; src_addr = 32'h0; dst_addr = 32'h60; len = 8'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, mem_read, mem_write} !== 4'b0 || addr !== 32'h0 || write_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_mid_outputs: got flags=%b addr=%h wdata=%h required 0", {busy, done, mem_read, mem_write},
                  addr, write_data);
      end
      seen_done = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (done) seen_done++;
      end
      tests_run++;
      if (seen_done != 0 || mem[24] !== 32'h101 || mem[25] !== 32'hFFFF0000 || mem[26] !== 32'hFFFF0000) begin
         tests_failed++;
         $display("FAIL reset_mid_abort: got done=%0d m24=%h m25=%h m26=%h required 0 101 ffff0000 ffff0000",
                  seen_done, mem[24], mem[25], mem[26]);
      end
      issue(1'b1, 32'h0, 32'hC0, 8'd2, 32'h10, -1);
      tests_run++;
      if (done_cyc != 3 || cks_at_done !== 32'h20 || mem[48] !== 32'h10 || mem[49] !== 32'h10) begin
         tests_failed++;
         $display("FAIL reset_mid_restart: got cyc=%0d cks=%h m48=%h m49=%h required 3 20 10 10",
                  done_cyc, cks_at_done, mem[48], mem[49]);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         tb_we = 1'b1; tb_idx = i[7:0]; tb_wd = 32'h0;
         @(posedge clk); #1;
      end
      tb_we = 1'b0;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_copy();
      test_fill();
      test_misaligned();
      test_len_zero();
      test_busy_start();
      test_overlap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
